// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU internal Bus: arbiter states, requester indices and default sizing.
package cpu_bus_pkg;

  localparam int DEFAULT_N_REQ = 8;

  localparam int REQ_PC  = 0;
  localparam int REQ_IMM = 1;
  localparam int REQ_ALU = 2;
  localparam int REQ_RF  = 3;
  localparam int REQ_MDR = 4;
  localparam int REQ_DM  = 5;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    TURN
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the control unit, the Bus arbiter and the drivers' output enables.
interface bus_arbiter_if #(
  parameter int N_REQ = cpu_bus_pkg::DEFAULT_N_REQ,
  parameter int IDW   = $clog2(N_REQ)
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] lock;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_valid;
  logic             bus_idle;
  logic             preempt;

  modport master (
    output req, lock,
    input  gnt, gnt_id, gnt_valid, bus_idle, preempt
  );

  modport slave (
    input  req, lock,
    output gnt, gnt_id, gnt_valid, bus_idle, preempt
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDW-1:0]   win_idx,
  output logic             any
);

  logic [IDW-1:0] cand;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((int'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        any     = 1'b1;
        win_idx = cand;
      end
    end
    if (any) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal Bus with hold limits, lock, and a dead interval on every handover.
module bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int N_REQ       = DEFAULT_N_REQ,
  parameter int IDW         = $clog2(N_REQ),
  parameter int MAX_HOLD    = 4,
  parameter int TURN_CYCLES = 1
) (
  input logic          clk,
  input logic          rst_n,
  bus_arbiter_if.slave bus
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             preempt_q, preempt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    hold_q, hold_d;
  logic [TW-1:0]    turn_q, turn_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             others_req;
  logic             hold_expired;
  logic             do_grant;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign owner_req    = bus.req[gnt_id_q];
  assign others_req   = |(bus.req & ~gnt_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q >= CW'(MAX_HOLD));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    turn_d      = turn_q;
    do_grant    = 1'b0;

    case (state_q)
      IDLE: do_grant = pick_any;
      OWN: begin
        if (!owner_req) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          turn_d      = '0;
          state_d     = others_req ? TURN : IDLE;
        end else if (hold_expired && !bus.lock[gnt_id_q] && others_req) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          preempt_d   = 1'b1;
          turn_d      = '0;
          state_d     = TURN;
        end else if (hold_q < CW'(MAX_HOLD)) begin
          hold_d = hold_q + CW'(1);
        end
      end
      TURN: begin
        if (turn_q == TW'(TURN_CYCLES - 1)) begin
          // Pointer already sits past the previous owner, so it wins again only when alone.
          do_grant = pick_any;
          if (!pick_any) state_d = IDLE;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      state_d     = OWN;
      gnt_d       = pick_oh;
      gnt_id_d    = pick_idx;
      gnt_valid_d = 1'b1;
      hold_d      = CW'(1);
      ptr_d       = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + IDW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= '0;
      turn_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      turn_q      <= turn_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.bus_idle  = ~gnt_valid_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus a random soak for the Bus arbiter; inputs change and outputs are sampled on the falling edge.
module tb_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam int N        = 8;
  localparam int MAXH     = 4;
  localparam int TURNC    = 1;
  localparam int STARVE   = (N - 1) * (MAXH + TURNC);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  bus_arbiter_if #(.N_REQ(N)) bus ();

  bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH), .TURN_CYCLES(TURNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    bus.req  = '0;
    bus.lock = '0;
    rst_n    = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    bus.req  = '0;
    bus.lock = '0;
    rst_n    = 1'b0;
    #1;
    total++; if (bus.gnt !== 8'h00)    begin bad++; $display("FAIL reset_gnt got=%h want=00", bus.gnt); end
    total++; if (bus.gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.gnt_valid); end
    total++; if (bus.bus_idle !== 1'b1)  begin bad++; $display("FAIL reset_idle got=%b want=1", bus.bus_idle); end
    total++; if (bus.preempt !== 1'b0)   begin bad++; $display("FAIL reset_preempt got=%b want=0", bus.preempt); end
    total++; if (bus.gnt_id !== 3'd0)    begin bad++; $display("FAIL reset_id got=%0d want=0", bus.gnt_id); end
    step(2);
    rst_n = 1'b1;
    step(1);
    bus.req = 8'h08;
    step(1);
    total++; if (bus.gnt !== 8'h08) begin bad++; $display("FAIL reset_pre_own got=%h want=08", bus.gnt); end
    // Assert reset between edges and look before the next rising edge.
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.gnt !== 8'h00)      begin bad++; $display("FAIL reset_async_gnt got=%h want=00", bus.gnt); end
    total++; if (bus.bus_idle !== 1'b1)  begin bad++; $display("FAIL reset_async_idle got=%b want=1", bus.bus_idle); end
    total++; if (bus.gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_async_valid got=%b want=0", bus.gnt_valid); end
    bus.req = '0;
    step(1);
    rst_n = 1'b1;
    step(2);
    total++; if (bus.gnt !== 8'h00 || bus.bus_idle !== 1'b1)
      begin bad++; $display("FAIL reset_after got gnt=%h idle=%b want gnt=00 idle=1", bus.gnt, bus.bus_idle); end
  endtask

  task automatic test_single;
    do_reset();
    bus.req = 8'h04;
    for (int c = 1; c <= 3; c++) begin
      step(1);
      total++; if (bus.gnt !== 8'h04 || bus.gnt_id !== 3'd2 || bus.gnt_valid !== 1'b1 || bus.bus_idle !== 1'b0)
        begin bad++; $display("FAIL single_own c%0d got gnt=%h id=%0d v=%b idle=%b want gnt=04 id=2 v=1 idle=0",
                              c, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.bus_idle); end
    end
    bus.req = '0;
    step(1);
    total++; if (bus.gnt !== 8'h00 || bus.bus_idle !== 1'b1)
      begin bad++; $display("FAIL single_release got gnt=%h idle=%b want gnt=00 idle=1", bus.gnt, bus.bus_idle); end
    total++; if (dut.state_q !== IDLE)
      begin bad++; $display("FAIL single_state got=%0d want=%0d", dut.state_q, IDLE); end
  endtask

  task automatic test_rr_turn;
    do_reset();
    bus.req = 8'h22;
    step(1);
    total++; if (bus.gnt !== 8'h02 || bus.gnt_id !== 3'd1)
      begin bad++; $display("FAIL rr_first got gnt=%h id=%0d want gnt=02 id=1", bus.gnt, bus.gnt_id); end
    bus.req = 8'h20;
    step(1);
    total++; if (bus.gnt !== 8'h00 || bus.bus_idle !== 1'b1 || bus.preempt !== 1'b0)
      begin bad++; $display("FAIL rr_turn1 got gnt=%h idle=%b pre=%b want gnt=00 idle=1 pre=0",
                            bus.gnt, bus.bus_idle, bus.preempt); end
    step(1);
    total++; if (bus.gnt !== 8'h20 || bus.gnt_id !== 3'd5)
      begin bad++; $display("FAIL rr_second got gnt=%h id=%0d want gnt=20 id=5", bus.gnt, bus.gnt_id); end
    bus.req = 8'h41;
    step(1);
    total++; if (bus.gnt !== 8'h00)
      begin bad++; $display("FAIL rr_turn2 got gnt=%h want=00", bus.gnt); end
    step(1);
    total++; if (bus.gnt !== 8'h40 || bus.gnt_id !== 3'd6)
      begin bad++; $display("FAIL rr_wrap got gnt=%h id=%0d want gnt=40 id=6", bus.gnt, bus.gnt_id); end
    bus.req = '0;
    step(2);
  endtask

  task automatic test_preempt;
    do_reset();
    bus.req = 8'h01;
    step(1);
    total++; if (bus.gnt !== 8'h01)
      begin bad++; $display("FAIL pre_own c1 got=%h want=01", bus.gnt); end
    bus.req = 8'h09;
    for (int c = 2; c <= 4; c++) begin
      step(1);
      total++; if (bus.gnt !== 8'h01 || bus.preempt !== 1'b0)
        begin bad++; $display("FAIL pre_own c%0d got gnt=%h pre=%b want gnt=01 pre=0", c, bus.gnt, bus.preempt); end
    end
    step(1);
    total++; if (bus.gnt !== 8'h00 || bus.preempt !== 1'b1 || bus.bus_idle !== 1'b1)
      begin bad++; $display("FAIL pre_pulse got gnt=%h pre=%b idle=%b want gnt=00 pre=1 idle=1",
                            bus.gnt, bus.preempt, bus.bus_idle); end
    step(1);
    total++; if (bus.gnt !== 8'h08 || bus.gnt_id !== 3'd3 || bus.preempt !== 1'b0)
      begin bad++; $display("FAIL pre_next got gnt=%h id=%0d pre=%b want gnt=08 id=3 pre=0",
                            bus.gnt, bus.gnt_id, bus.preempt); end
    bus.req = '0;
    step(2);
  endtask

  task automatic test_lock;
    do_reset();
    bus.lock = 8'h01;
    bus.req  = 8'h01;
    step(1);
    bus.req = 8'h09;
    for (int c = 2; c <= 8; c++) begin
      step(1);
      total++; if (bus.gnt !== 8'h01 || bus.preempt !== 1'b0)
        begin bad++; $display("FAIL lock_hold c%0d got gnt=%h pre=%b want gnt=01 pre=0", c, bus.gnt, bus.preempt); end
    end
    bus.lock = '0;
    step(1);
    total++; if (bus.gnt !== 8'h00 || bus.preempt !== 1'b1)
      begin bad++; $display("FAIL lock_release got gnt=%h pre=%b want gnt=00 pre=1", bus.gnt, bus.preempt); end
    step(1);
    total++; if (bus.gnt !== 8'h08)
      begin bad++; $display("FAIL lock_next got gnt=%h want=08", bus.gnt); end
    bus.req = '0;
    step(2);
  endtask

  task automatic test_rewin;
    do_reset();
    bus.req = 8'h01;
    step(1);
    bus.req = 8'h09;
    step(4);
    total++; if (bus.preempt !== 1'b1)
      begin bad++; $display("FAIL rewin_pulse got pre=%b want=1", bus.preempt); end
    bus.req = 8'h01;
    step(1);
    total++; if (bus.gnt !== 8'h01 || bus.preempt !== 1'b0)
      begin bad++; $display("FAIL rewin_sole got gnt=%h pre=%b want gnt=01 pre=0", bus.gnt, bus.preempt); end
    bus.req = '0;
    step(2);
  endtask

  task automatic test_soak;
    logic [N-1:0] want;
    logic [2:0]   last_id;
    logic         had_owner;
    int           zero_run;
    int           wait_c [N];
    int           worst;
    bit           lock_phase;
    do_reset();
    want      = '0;
    last_id   = '0;
    had_owner = 1'b0;
    zero_run  = 0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      lock_phase = (cyc >= 6000);
      total++; if (!$onehot0(bus.gnt))
        begin bad++; if (bad < 30) $display("FAIL soak_onehot cyc%0d got gnt=%h want at most one bit", cyc, bus.gnt); end
      total++; if (bus.bus_idle !== !bus.gnt_valid || bus.gnt_valid !== |bus.gnt)
        begin bad++; if (bad < 30) $display("FAIL soak_flags cyc%0d got idle=%b v=%b gnt=%h want idle=!v v=|gnt",
                                           cyc, bus.bus_idle, bus.gnt_valid, bus.gnt); end
      total++; if (bus.preempt && bus.gnt_valid)
        begin bad++; if (bad < 30) $display("FAIL soak_preempt cyc%0d got pre=1 v=1 want v=0", cyc); end
      if (bus.gnt_valid) begin
        total++; if (bus.gnt !== (8'(1) << bus.gnt_id))
          begin bad++; if (bad < 30) $display("FAIL soak_id cyc%0d got gnt=%h id=%0d want matching", cyc, bus.gnt, bus.gnt_id); end
        if (had_owner && bus.gnt_id != last_id) begin
          total++; if (zero_run < TURNC)
            begin bad++; if (bad < 30) $display("FAIL soak_turn cyc%0d got dead=%0d want>=%0d", cyc, zero_run, TURNC); end
        end
        had_owner = 1'b1;
        last_id   = bus.gnt_id;
        zero_run  = 0;
      end else begin
        zero_run++;
      end
      if (!lock_phase) begin
        worst = 0;
        for (int i = 0; i < N; i++) begin
          if (bus.req[i] && !bus.gnt[i]) wait_c[i]++;
          else wait_c[i] = 0;
          if (wait_c[i] > worst) worst = wait_c[i];
        end
        // The dead cycle right after losing the Bus is not part of the rotation bound.
        total++; if (worst > STARVE + TURNC)
          begin bad++; if (bad < 30) $display("FAIL soak_starve cyc%0d got wait=%0d want<=%0d", cyc, worst, STARVE + TURNC); end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          if ($urandom_range(2) == 0) want[i] = 1'b0;
        end else if (!want[i] && $urandom_range(3) == 0) begin
          want[i] = 1'b1;
        end
      end
      bus.req  = want;
      bus.lock = lock_phase ? (8'($urandom) & 8'($urandom)) : '0;
      step(1);
    end
    bus.req  = '0;
    bus.lock = '0;
    step(2);
  endtask

  initial begin
    bus.req  = '0;
    bus.lock = '0;
    test_reset();
    test_single();
    test_rr_turn();
    test_preempt();
    test_lock();
    test_rewin();
    test_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Time-shares the single internal 32-bit Bus of the multi-cycle CPU among its tri-state drivers (PC, immediate extender, ALU, register file, MDR, data memory, spare ports) so that at most one drive enable is asserted in any cycle. It uses round-robin arbitration with per-owner hold limits, optional lock, and a forced dead (turnaround) interval whenever Bus ownership changes hands. It sits between the control unit's drive requests and the drivers' output-enable pins.

Parameters:
N_REQ, 8, number of Bus drivers/requesters (2..16)
IDW, $clog2(N_REQ), width of gnt_id
MAX_HOLD, 4, max consecutive OWN cycles before preemption if others wait; 0 = unlimited
TURN_CYCLES, 1, dead cycles inserted between two different owners (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-driver Bus request, level, held until done
lock  input  N_REQ  per-driver lock; while owner's bit is 1 it cannot be preempted
gnt  output  N_REQ  registered one-hot drive enable; wire directly to driver Oe
gnt_id  output  IDW  index of current owner; valid only when gnt_valid=1
gnt_valid  output  1  1 when any gnt bit set
bus_idle  output  1  1 in IDLE and TURN (no driver enabled)
preempt  output  1  one-cycle pulse on the cycle the owner loses gnt due to MAX_HOLD

Behaviour:
- Reset (async, rst_n=0): gnt=0, gnt_id=0, gnt_valid=0, bus_idle=1, preempt=0, rr pointer=0, hold count=0, state=IDLE. Takes effect without a clock edge, including mid-OWN.
- States: IDLE, OWN, TURN. All outputs registered; gnt never has more than one bit set.
- Round-robin pick: search req ascending from ptr, wrapping mod N_REQ; first set bit wins. On every grant, ptr <= winner+1 (wraps N_REQ-1 -> 0).
- IDLE: if req!=0 -> OWN next edge with gnt[winner]=1 (latency 1 cycle from req to gnt); hold count <= 1. Else stay.
- OWN (owner o):
  - req[o]=0 -> gnt<=0; go TURN if any other req set, else IDLE.
  - req[o]=1, MAX_HOLD!=0, count>=MAX_HOLD, lock[o]=0, some other req set -> gnt<=0, preempt<=1 for that cycle, go TURN.
  - otherwise stay; count increments, saturating at MAX_HOLD.
  - lock[o] without req[o] has no effect.
- TURN: gnt=0 for exactly TURN_CYCLES cycles. On the last cycle arbitrate on current req (ptr already past previous owner): any set -> OWN with new winner, count<=1; none -> IDLE. The preempted owner may win again only if it is the sole requester.
- Requests that drop before being granted are forgotten; no queueing.
- Simultaneous release by owner and new req by same index in the same cycle: treated as release, goes through TURN/IDLE.
- bus_idle = !gnt_valid at all times.

Decomposition:
- Shared package cpu_bus_pkg: arb_state_t enum (IDLE, OWN, TURN), requester index constants (REQ_PC=0, REQ_IMM=1, REQ_ALU=2, REQ_RF=3, REQ_MDR=4, REQ_DM=5), default N_REQ.
- One sub-module: rr_pick (combinational; req + ptr -> one-hot winner, index, any). Arbiter FSM, counters and pointer remain in bus_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-run with gnt[3]=1 -> gnt=0, bus_idle=1, gnt_valid=0 immediately, before next clk edge; after release and req=0, outputs stay idle.
- Single requester: req[2]=1 for 3 cycles from IDLE -> gnt[2]=1 from cycle 1 to cycle 3, gnt_id=2; req drop -> next cycle gnt=0, IDLE, no TURN.
- Round-robin plus turnaround: req[1] and req[5] set together after reset -> gnt[1] first; req[1] drops -> 1 cycle all-zero (TURN) -> gnt[5], gnt_id=5; then req[0] and req[6] set -> 6 wins (ptr=6).
- Preemption: req[0] held, req[3] raised during OWN of 0, MAX_HOLD=4 -> gnt[0] exactly 4 cycles, preempt=1 on cycle gnt[0] falls, 1 dead cycle, then gnt[3].
- Lock: same as preemption with lock[0]=1 -> gnt[0] holds past 4 cycles, no preempt; lock[0] drops -> next edge preempt pulse, TURN, gnt[3].
- Exclusivity soak: random req/lock over 10k cycles, N_REQ=8 -> $onehot0(gnt) every cycle, >=TURN_CYCLES zero cycles between different owners, no requester starved beyond (N_REQ-1)*(MAX_HOLD+TURN_CYCLES) cycles when none locks.
